pdm_decimator: RTL and testbench

Receive-side counterpart of the synth's PDM `dac`: converts a 1-bit pulse-density stream back into signed 12-bit PCM samples with a 3rd-order CIC decimator and an output saturator. It is used on the bench and in loopback to recover `soundproc` output from the `dac` bitstream. It also serves as the front end for a future PDM microphone input path.

---
 rtl/synth_pkg.sv | 10 +
 rtl/cic_integrator_chain.sv | 47 ++++
 rtl/pdm_decimator.sv | 72 +++++++
 tb/tb_pdm_decimator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and helpers for the synth audio blocks
package synth_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 2;
    endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: three modulo-2**W integrators, frame phase counter and decimated sample capture
module cic_integrator_chain
    import synth_pkg::*;
#(
    parameter int DECIM_LOG2 = 6,
    parameter int W          = cic_width(DECIM_LOG2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pdm_en,
    input  logic         pdm_in,
    output logic [W-1:0] sample,
    output logic         strobe
);

    logic [W-1:0]          i1;
    logic [W-1:0]          i2;
    logic [W-1:0]          i3;
    logic [DECIM_LOG2-1:0] phase;
    logic [W-1:0]          step;
    logic                  frame_end;

    assign step      = pdm_in ? W'(1) : '1;
    assign frame_end = pdm_en && (phase == '1);

    // integrate each enabled bit; on the last bit of a frame capture the new I3 and flag the combs
    always_ff @(posedge clk) begin
        if (rst) begin
            i1     <= '0;
            i2     <= '0;
            i3     <= '0;
            phase  <= '0;
            sample <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= frame_end;
            if (pdm_en) begin
                i1    <= i1 + step;
                i2    <= i2 + i1;
                i3    <= i3 + i2;
                phase <= phase + 1'b1;
                if (frame_end) sample <= i3 + i2;
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: 3rd-order CIC decimator turning a PDM bitstream into saturated signed PCM
module pdm_decimator
    import synth_pkg::*;
#(
    parameter int DATA_BITS  = 12,
    parameter int DECIM_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pdm_en,
    input  logic                 pdm_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid
);

    localparam int             W      = cic_width(DECIM_LOG2);
    localparam logic [W-1:0]   POS_FS = W'(1) << (W - 2);

    logic [W-1:0]         sample;
    logic                 strobe;
    logic [W-1:0]         d1;
    logic [W-1:0]         d2;
    logic [W-1:0]         d3;
    logic [W-1:0]         c1;
    logic [W-1:0]         c2;
    logic [W-1:0]         c3;
    logic [1:0]           prime;
    logic [DATA_BITS-1:0] sat;

    cic_integrator_chain #(.DECIM_LOG2(DECIM_LOG2), .W(W)) u_int (
        .clk    (clk),
        .rst    (rst),
        .pdm_en (pdm_en),
        .pdm_in (pdm_in),
        .sample (sample),
        .strobe (strobe)
    );

    // the only out-of-range comb result is exactly +full-scale, which clamps to the largest code
    always_comb begin
        c1  = sample - d1;
        c2  = c1 - d2;
        c3  = c2 - d3;
        sat = (c3 == POS_FS) ? {1'b0, {(DATA_BITS-1){1'b1}}} : c3[W-2 -: DATA_BITS];
    end

    // advance the comb delays per decimated sample; hold off the output until the delays are filled
    always_ff @(posedge clk) begin
        if (rst) begin
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            prime      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (strobe) begin
                d1 <= sample;
                d2 <= c1;
                d3 <= c2;
                if (prime == 2'd3) begin
                    dout       <= sat;
                    dout_valid <= 1'b1;
                end else begin
                    prime <= prime + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: scoreboard bench comparing the decimator against a binomial-sum CIC model
module tb_pdm_decimator;

    localparam int R = 64;

    typedef struct {
        logic [11:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pdm_en = 1'b0;
    logic        pdm_in = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic        rst_q = 1'b1;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [11:0] exp_hold = '0;
    bit          tol_active = 1'b0;
    int          tol_target = 0;

    int          xs[$];
    longint      shist[$];
    int          nbits = 0;
    int          sd_acc = 0;

    pdm_decimator #(.DATA_BITS(12), .DECIM_LOG2(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .pdm_en     (pdm_en),
        .pdm_in     (pdm_in),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Triple integration of the +-1 stream from zero: I3(n) = sum_j x_j * C(n-1-j, 2)
    function automatic longint i3_at(int n);
        longint s = 0;
        for (int j = 0; j < n; j++)
            s += longint'(xs[j]) * longint'(n - 1 - j) * longint'(n - 2 - j) / 2;
        return s;
    endfunction

    task automatic consume(int x);
        longint y;
        int     k;
        exp_t   e;
        xs.push_back(x);
        nbits++;
        if (nbits % R == 0) begin
            shist.push_back(i3_at(nbits));
            k = shist.size();
            if (k >= 4) begin
                y = shist[k-1] - 3 * shist[k-2] + 3 * shist[k-3] - shist[k-4];
                if (y > longint'((1 << 18) - 1)) y = longint'((1 << 18) - 1);
                e.val = 12'(y >>> 7);
                e.cyc = cyc + 1;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic step(bit en, bit x);
        pdm_en = en;
        pdm_in = x;
        @(posedge clk);
        #1;
        if (en) consume(x ? 1 : -1);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pdm_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        xs.delete();
        shist.delete();
        nbits  = 0;
        sd_acc = 0;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'($urandom_range(0, 1)));
    endtask

    // mode 0 ones, 1 zeros, 2 alternating, 3 random with p% ones, 4 first-order sigma-delta of value p
    task automatic run(int n, int mode, int p, int gate);
        int done = 0;
        int ph = 0;
        int v;
        bit en;
        bit b;
        while (done < n) begin
            en = (gate == 0) ? 1'($urandom_range(0, 1)) : ((ph % gate) == gate - 1);
            ph++;
            b = 1'($urandom_range(0, 1));
            if (en) begin
                done++;
                if (mode == 0) b = 1'b1;
                else if (mode == 1) b = 1'b0;
                else if (mode == 2) b = (nbits % 2 == 0);
                else if (mode == 3) b = ($urandom_range(0, 99) < p);
                else begin
                    v      = sd_acc + p;
                    b      = (v >= 0);
                    sd_acc = v - (b ? 2048 : -2048);
                end
            end
            step(en, b);
        end
    endtask

    // monitor: pop expectations on every strobe, check hold and timing otherwise
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            exp_hold = '0;
        end else if (rst_q) begin
            vectors++;
            if (dout !== 12'h000 || dout_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d dout=%h valid=%b want dout=000 valid=0", cyc, dout, dout_valid);
            end
        end else if (dout_valid === 1'b1) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid cyc=%0d dout=%h want no valid", cyc, dout);
            end else begin
                mon_e = sbq.pop_front();
                if (dout !== mon_e.val || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL sample cyc=%0d dout=%h want cyc=%0d dout=%h", cyc, dout, mon_e.cyc, mon_e.val);
                end
                exp_hold = mon_e.val;
            end
            if (tol_active) begin
                vectors++;
                if (int'($signed(dout)) > tol_target + 2 || int'($signed(dout)) < tol_target - 2) begin
                    miscompares++;
                    $display("FAIL settle cyc=%0d dout=%0d want %0d+-2", cyc, $signed(dout), tol_target);
                end
            end
        end else begin
            vectors++;
            if (dout !== exp_hold) begin
                miscompares++;
                $display("FAIL hold cyc=%0d dout=%h want %h", cyc, dout, exp_hold);
            end
            if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                miscompares++;
                mon_e = sbq.pop_front();
                $display("FAIL missing_valid cyc=%0d valid=0 want valid with dout=%h at cyc=%0d", cyc, mon_e.val, mon_e.cyc);
                exp_hold = mon_e.val;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d stimulus did not complete", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(); run(10 * R, 0, 0, 1); idle(4);
        do_reset(); run(10 * R, 1, 0, 1); idle(4);
        do_reset(); run(10 * R, 2, 0, 1); idle(4);
        tol_target = 1024;  tol_active = 1'b1;
        do_reset(); run(10 * R, 4, 1024, 1); idle(4);
        tol_target = -1536;
        do_reset(); run(10 * R, 4, -1536, 1); idle(4);
        tol_active = 1'b0;
        do_reset(); run(6 * R, 0, 0, 4); idle(8);
        do_reset(); run(R / 2, 0, 0, 1);
        do_reset(); run(6 * R, 0, 0, 1); idle(4);
        do_reset(); run(8 * R, 3, 50, 1); run(8 * R, 3, 80, 0); run(4 * R, 3, 10, 2); idle(8);
        do_reset(); run(5 * R, 1, 0, 1);
        do_reset(); run(5 * R, 3, 70, 1); idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
